// File: rtl/gf180_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// gf180_ram_ctrl_if
//   Core-side channel bundle for gf180_ram_ctrl. The bundle holds a
//   valid/ready request channel, a valid/ready read-response channel and the
//   init_done status flag.
//
//   Signals:
//     req_valid  requester -> ctrl  request present
//     req_ready  ctrl -> requester  request accepted on valid && ready
//     req_we     requester -> ctrl  1 = write, 0 = read
//     req_addr   requester -> ctrl  word address
//     req_wdata  requester -> ctrl  write data
//     req_bmask  requester -> ctrl  per-bit write enable, active-high
//     resp_valid ctrl -> requester  read data available
//     resp_ready requester -> ctrl  consumer accepts read data
//     resp_data  ctrl -> requester  head of the response FIFO
//     init_done  ctrl -> requester  array clear finished / block usable
//
//   Modports:
//     master  the requester side
//     slave   the controller side
// ---------------------------------------------------------------------------
interface gf180_ram_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic [7:0] req_bmask;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_data;
  logic       init_done;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_bmask, resp_ready,
    input  req_ready, resp_valid, resp_data, init_done
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_bmask, resp_ready,
    output req_ready, resp_valid, resp_data, init_done
  );
endinterface

// File: rtl/gf180_ram_ctrl.sv
// ---------------------------------------------------------------------------
// gf180_ram_ctrl
//   Front-end for the gf180 256x8 SRAM wrapper. The controller drives the
//   wrapper's active-low macro pins from a valid/ready request channel and
//   returns read data through a 2-entry response FIFO. The read latency is
//   2 cycles. The controller can optionally sweep INIT_VALUE into every
//   word after reset, before it accepts traffic.
//
//   Parameters:
//     CLEAR_ON_RESET  1: run the 256-cycle clear sweep after reset
//     INIT_VALUE      data written by the sweep
//
//   Ports:
//     CLK       clock, rising edge
//     RST_N     asynchronous active-low reset
//     bus       core-side channel (slave modport of gf180_ram_ctrl_if)
//     ram_cen   wrapper CEN, active-low chip enable
//     ram_gwen  wrapper GWEN, active-low global write enable
//     ram_wen   wrapper WEN, active-low per-bit write enable
//     ram_a     wrapper address
//     ram_d     wrapper write data
//     ram_q     wrapper read data; valid the cycle after a read
// ---------------------------------------------------------------------------
module gf180_ram_ctrl #(
  parameter bit         CLEAR_ON_RESET = 1'b1,
  parameter logic [7:0] INIT_VALUE     = 8'h00
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  gf180_ram_ctrl_if.slave       bus,
  output logic                  ram_cen,
  output logic                  ram_gwen,
  output logic [7:0]            ram_wen,
  output logic [7:0]            ram_a,
  output logic [7:0]            ram_d,
  input  logic [7:0]            ram_q
);

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_init_cnt;
  logic [ADDR_W-1:0]   w_init_cnt_nxt;
  logic                r_init_done;
  logic                w_init_done_nxt;

  logic                r_rd_pending;
  logic [1:0]          r_count;
  logic                r_wptr;
  logic                r_rptr;
  logic [DATA_W-1:0]   r_fifo [2];

  logic                w_req_ready;
  logic                w_fire;
  logic                w_rd_fire;
  logic                w_push;
  logic                w_pop;
  logic [2:0]          w_credit;

  // ------------------------------------------------------------------
  // Handshake and flow control.
  // ------------------------------------------------------------------
  // The credit count covers entries already in the FIFO and the read that
  // is in flight through the macro. A pop in this cycle frees a slot
  // immediately, so reads continue at full rate while the consumer drains.
  // RST_N gates ready so that no request is accepted while reset is
  // asserted. This also applies when init_done resets high.
  assign w_pop       = (r_count != 2'd0) && bus.resp_ready;
  assign w_push      = r_rd_pending;
  assign w_credit    = {1'b0, r_count} + {2'b00, r_rd_pending} - {2'b00, w_pop};
  assign w_req_ready = RST_N && r_init_done && (bus.req_we || (w_credit < 3'd2));
  assign w_fire      = bus.req_valid && w_req_ready;
  assign w_rd_fire   = w_fire && !bus.req_we;

  assign bus.req_ready  = w_req_ready;
  assign bus.resp_valid = (r_count != 2'd0);
  assign bus.resp_data  = r_fifo[r_rptr];
  assign bus.init_done  = r_init_done;

  // ------------------------------------------------------------------
  // FSM state register.
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
      r_init_cnt  <= '0;
      r_init_done <= !CLEAR_ON_RESET;
    end else begin
      r_state     <= w_state_nxt;
      r_init_cnt  <= w_init_cnt_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM next state and macro pin drive.
  // ------------------------------------------------------------------
  // While reset is asserted the pins idle combinationally. A reset in the
  // middle of the sweep therefore stops macro activity at once, without
  // waiting for a clock edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_init_cnt_nxt  = r_init_cnt;
    w_init_done_nxt = r_init_done;
    ram_cen         = 1'b1;
    ram_gwen        = 1'b1;
    ram_wen         = 8'hFF;
    ram_a           = '0;
    ram_d           = '0;

    if (RST_N) begin
      unique case (r_state)
        ST_INIT: begin
          ram_cen        = 1'b0;
          ram_gwen       = 1'b0;
          ram_wen        = 8'h00;
          ram_a          = r_init_cnt;
          ram_d          = INIT_VALUE;
          w_init_cnt_nxt = r_init_cnt + 8'd1;
          // This edge writes the last word, so the sweep ends here.
          if (r_init_cnt == 8'hFF) begin
            w_state_nxt     = ST_RUN;
            w_init_done_nxt = 1'b1;
          end
        end
        ST_RUN: begin
          ram_a    = bus.req_addr;
          ram_d    = bus.req_wdata;
          ram_cen  = !w_fire;
          ram_gwen = !(w_fire && bus.req_we);
          ram_wen  = (w_fire && bus.req_we) ? ~bus.req_bmask : 8'hFF;
        end
        default: ;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Read pipeline control: macro access, then capture into the FIFO.
  // ------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rd_pending <= 1'b0;
      r_count      <= 2'd0;
      r_wptr       <= 1'b0;
      r_rptr       <= 1'b0;
    end else begin
      r_rd_pending <= w_rd_fire;
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // FIFO storage holds data only and needs no reset. The occupancy count
  // decides whether an entry is meaningful.
  always_ff @(posedge CLK) begin
    if (w_push) r_fifo[r_wptr] <= ram_q;
  end

  // The credit check must keep the FIFO from ever taking a third entry.
  always_ff @(posedge CLK) begin
    if (RST_N) begin
      assert (!(w_push && !w_pop && (r_count == 2'd2)));
    end
  end

endmodule

// File: tb/tb_gf180_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gf180_ram_ctrl
//   Directed bench for gf180_ram_ctrl. The bench has two instances:
//     dut0  CLEAR_ON_RESET=1, INIT_VALUE=8'hA5, with a behavioural 256x8
//           macro model attached
//     dut1  CLEAR_ON_RESET=0, with no traffic
// ---------------------------------------------------------------------------
module tb_gf180_ram_ctrl;

  logic clk = 1'b0;
  logic rst0_n;
  logic rst1_n;
  always #5 clk = ~clk;

  gf180_ram_ctrl_if b0 ();
  gf180_ram_ctrl_if b1 ();

  logic       cen0, gwen0, cen1, gwen1;
  logic [7:0] wen0, a0, d0, q0, wen1, a1, d1;

  gf180_ram_ctrl #(.CLEAR_ON_RESET(1'b1), .INIT_VALUE(8'hA5)) dut0 (
    .CLK(clk), .RST_N(rst0_n), .bus(b0),
    .ram_cen(cen0), .ram_gwen(gwen0), .ram_wen(wen0),
    .ram_a(a0), .ram_d(d0), .ram_q(q0)
  );

  gf180_ram_ctrl #(.CLEAR_ON_RESET(1'b0), .INIT_VALUE(8'h00)) dut1 (
    .CLK(clk), .RST_N(rst1_n), .bus(b1),
    .ram_cen(cen1), .ram_gwen(gwen1), .ram_wen(wen1),
    .ram_a(a1), .ram_d(d1), .ram_q(8'h00)
  );

  // Behavioural macro: the write is masked per bit by active-low WEN, and
  // read data is registered on the access edge.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (!cen0) begin
      if (!gwen0) mem[a0] <= (mem[a0] & wen0) | (d0 & ~wen0);
      else        q0      <= mem[a0];
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv_idle();
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = 8'h00;
    b0.req_wdata = 8'h00; b0.req_bmask = 8'h00; b0.resp_ready = 1'b0;
  endtask

  task automatic drv_rd(input logic [7:0] addr);
    b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.req_addr = addr;
  endtask

  task automatic drv_wr(input logic [7:0] addr, input logic [7:0] data, input logic [7:0] mask);
    b0.req_valid = 1'b1; b0.req_we = 1'b1; b0.req_addr = addr;
    b0.req_wdata = data; b0.req_bmask = mask;
  endtask

  // Call this just after reset release. It follows the 256-cycle sweep
  // edge by edge.
  task automatic sweep_check(input string tag);
    for (int c = 0; c < 256; c++) begin
      chk({tag, "_a"}, a0, c);
      chk({tag, "_gwen"}, gwen0, 1'b0);
      chk({tag, "_rdy"}, b0.req_ready, 1'b0);
      if (c == 0 || c == 255) chk({tag, "_done_lo"}, b0.init_done, 1'b0);
      tick();
    end
    chk({tag, "_done_hi"}, b0.init_done, 1'b1);
    chk({tag, "_idle_cen"}, cen0, 1'b1);
    chk({tag, "_idle_gwen"}, gwen0, 1'b1);
  endtask

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    drv_idle();
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 8'h00;
    b1.req_wdata = 8'h00; b1.req_bmask = 8'h00; b1.resp_ready = 1'b0;
    repeat (3) tick();

    // Values while reset is asserted.
    chk("rst_done",  b0.init_done, 1'b0);
    chk("rst_rdy",   b0.req_ready, 1'b0);
    chk("rst_rvld",  b0.resp_valid, 1'b0);
    chk("rst_cen",   cen0, 1'b1);
    chk("rst_gwen",  gwen0, 1'b1);
    chk("rst_wen",   wen0, 8'hFF);
    chk("rst_a",     a0, 8'h00);
    chk("rst_d",     d0, 8'h00);
    chk("d1_rst_done", b1.init_done, 1'b1);
    chk("d1_rst_rdy",  b1.req_ready, 1'b0);

    // Instance without the clear sweep is usable right after release.
    rst1_n = 1'b1;
    #1;
    chk("d1_done", b1.init_done, 1'b1);
    chk("d1_rdy",  b1.req_ready, 1'b1);
    chk("d1_cen",  cen1, 1'b1);
    tick();
    tick();
    chk("d1_cen_idle", cen1, 1'b1);
    chk("d1_gwen_idle", gwen1, 1'b1);

    // Clear sweep after the first reset release.
    rst0_n = 1'b1;
    #1;
    chk("sw1_d", d0, 8'hA5);
    sweep_check("sw1");

    // Read of a cleared word.
    drv_rd(8'h7F);
    #1;
    chk("rd7f_rdy", b0.req_ready, 1'b1);
    chk("rd7f_cen", cen0, 1'b0);
    tick();
    drv_idle();
    #1;
    chk("rd7f_vld_n1", b0.resp_valid, 1'b0);
    tick();
    chk("rd7f_vld_n2", b0.resp_valid, 1'b1);
    chk("rd7f_data", b0.resp_data, 8'hA5);
    b0.resp_ready = 1'b1;
    tick();
    b0.resp_ready = 1'b0;
    chk("rd7f_drained", b0.resp_valid, 1'b0);

    // Full-mask write, then read back.
    drv_wr(8'h10, 8'h3C, 8'hFF);
    #1;
    chk("wr10_rdy", b0.req_ready, 1'b1);
    chk("wr10_wen", wen0, 8'h00);
    chk("wr10_gwen", gwen0, 1'b0);
    chk("wr10_a", a0, 8'h10);
    tick();
    drv_rd(8'h10);
    #1;
    chk("rd10_gwen", gwen0, 1'b1);
    tick();
    drv_idle();
    #1;
    chk("rd10_vld_n1", b0.resp_valid, 1'b0);
    tick();
    chk("rd10_vld_n2", b0.resp_valid, 1'b1);
    chk("rd10_data", b0.resp_data, 8'h3C);
    b0.resp_ready = 1'b1;
    tick();
    b0.resp_ready = 1'b0;

    // Partial-mask write: only the low nibble changes, 3C -> 33.
    drv_wr(8'h10, 8'hC3, 8'h0F);
    #1;
    chk("wrpm_wen", wen0, 8'hF0);
    tick();
    drv_rd(8'h10);
    tick();
    drv_idle();
    tick();
    chk("rdpm_vld", b0.resp_valid, 1'b1);
    chk("rdpm_data", b0.resp_data, 8'h33);
    b0.resp_ready = 1'b1;
    tick();
    b0.resp_ready = 1'b0;

    // Preload 01..04 with 11..44.
    for (int i = 1; i <= 4; i++) begin
      drv_wr(8'(i), 8'(i * 17), 8'hFF);
      tick();
    end

    // Back-to-back reads against a stalled consumer.
    drv_rd(8'h01);
    #1;
    chk("bb1_rdy", b0.req_ready, 1'b1);
    tick();
    drv_rd(8'h02);
    #1;
    chk("bb2_rdy", b0.req_ready, 1'b1);
    tick();
    drv_rd(8'h03);
    #1;
    chk("bb3_blocked", b0.req_ready, 1'b0);
    chk("bb3_cen", cen0, 1'b1);
    tick();
    chk("bb3_still_blocked", b0.req_ready, 1'b0);
    chk("bb_head_vld", b0.resp_valid, 1'b1);
    chk("bb_head", b0.resp_data, 8'h11);
    drv_wr(8'h05, 8'h55, 8'hFF);
    #1;
    chk("bb_wr_rdy", b0.req_ready, 1'b1);
    chk("bb_wr_gwen", gwen0, 1'b0);
    tick();
    drv_rd(8'h03);
    #1;
    chk("bb3_reblocked", b0.req_ready, 1'b0);
    b0.resp_ready = 1'b1;
    #1;
    chk("bb3_unblocked", b0.req_ready, 1'b1);
    tick();
    chk("bb_d22", b0.resp_data, 8'h22);
    drv_rd(8'h04);
    #1;
    chk("bb4_rdy", b0.req_ready, 1'b1);
    tick();
    b0.req_valid = 1'b0;
    #1;
    chk("bb_d33_vld", b0.resp_valid, 1'b1);
    chk("bb_d33", b0.resp_data, 8'h33);
    tick();
    chk("bb_d44_vld", b0.resp_valid, 1'b1);
    chk("bb_d44", b0.resp_data, 8'h44);
    tick();
    chk("bb_empty", b0.resp_valid, 1'b0);
    drv_idle();

    // Reset in RUN discards a buffered response.
    drv_rd(8'h05);
    tick();
    drv_idle();
    tick();
    chk("rr_vld", b0.resp_valid, 1'b1);
    chk("rr_data", b0.resp_data, 8'h55);
    rst0_n = 1'b0;
    #1;
    chk("rr_flushed", b0.resp_valid, 1'b0);
    chk("rr_done_lo", b0.init_done, 1'b0);
    tick();
    rst0_n = 1'b1;
    #1;

    // Reset at init_cnt=100 restarts the sweep.
    repeat (100) tick();
    chk("mid_a100", a0, 8'd100);
    chk("mid_cen_act", cen0, 1'b0);
    rst0_n = 1'b0;
    #1;
    chk("mid_cen", cen0, 1'b1);
    chk("mid_gwen", gwen0, 1'b1);
    chk("mid_wen", wen0, 8'hFF);
    chk("mid_a", a0, 8'h00);
    chk("mid_d", d0, 8'h00);
    chk("mid_rvld", b0.resp_valid, 1'b0);
    tick();
    tick();
    rst0_n = 1'b1;
    #1;
    sweep_check("sw2");

    // The cleared array reads back INIT_VALUE again.
    drv_rd(8'h03);
    tick();
    drv_idle();
    tick();
    chk("post_vld", b0.resp_valid, 1'b1);
    chk("post_data", b0.resp_data, 8'hA5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so that the run ends even if the sequence stalls.
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
